mealy_pattern_tx: RTL and testbench
===================================

Name: mealy_pattern_tx

Overview:
- Serial bit-pattern transmitter. It is the stimulus-side counterpart of the mealy_6 sequence detector: it generates the serial x stream that the detector consumes.
- It loads an up-to-PAT_W-bit pattern and shifts it out MSB-first, one bit per clock. The pattern repeats a programmable number of times, with optional idle gap cycles between repetitions.
- It sits between a control/test driver and the detector's x input, and reports busy/done/err.

Parameters:
- PAT_W, 8, maximum pattern length in bits.
- LEN_W, 4, width of len; must satisfy 2^LEN_W > PAT_W.
- CNT_W, 4, width of the repetition count.
- GAP, 0, number of idle cycles (x_valid=0, x=0) inserted between repetitions; 0 means back-to-back.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request to transmit; sampled only in IDLE.
- pattern  in  PAT_W  pattern bits; the low len bits are used, bit len-1 is sent first.
- len  in  LEN_W  pattern length; legal range 1..PAT_W.
- reps  in  CNT_W  repetition count; legal range 1..2^CNT_W-1.
- abort  in  1  synchronous cancel of an in-progress transmission.
- x  out  1  serial data bit; drives the detector's x input.
- x_valid  out  1  x carries a pattern bit this cycle.
- busy  out  1  transmission in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done: request was rejected for illegal len/reps.

Behaviour:
- Reset (rst low, asynchronous):
  - x=0, x_valid=0, busy=0, done=0, err=0.
  - Internal counters cleared; state=IDLE.
  - Reset asserted mid-transmission aborts immediately, with no done pulse.
- All outputs are registered. States are IDLE, SEND, GAP and DONE.
- IDLE:
  - start=1 with legal len and reps: capture pattern, len and reps into shadow registers; bit_idx=len-1; rep_left=reps; go to SEND.
  - busy=1 and the first x_valid=1 both appear on the edge after start is sampled. Latency is 1 cycle.
  - start=1 with len=0, len>PAT_W or reps=0: no bits are sent. done=1 and err=1 for one cycle on the next edge; busy stays 0; go to DONE.
- SEND:
  - Each cycle x = shadow[bit_idx], x_valid=1, busy=1, then bit_idx decrements.
  - After sending bit 0, decrement rep_left.
  - If rep_left was 1, go to DONE.
  - Else, if GAP>0, go to GAP.
  - Else, reload bit_idx=len-1 and stay in SEND with no bubble.
- GAP: x=0, x_valid=0, busy=1 for exactly GAP cycles, then reload bit_idx=len-1 and go to SEND.
- DONE:
  - done=1 (err=0 for a normal finish), busy=0, x_valid=0, x=0 for one cycle, then go to IDLE.
  - start asserted during the DONE cycle is ignored; a new request is accepted from the following cycle.
- Total busy cycles for a normal run: len*reps + GAP*(reps-1). done follows the last bit on the next cycle.
- abort:
  - Honoured only in SEND or GAP, and has priority over every other transition.
  - On the next edge: x=0, x_valid=0, busy=0, done=1, err=0; then go to IDLE via DONE.
  - abort in IDLE or DONE has no effect.
- start while busy is ignored. Changes to pattern, len or reps while busy have no effect, because the shadow registers are used.
- x is 0 whenever x_valid=0.

Test Plan:
- Alternating stream: pattern=4'b1010 (len=4), reps=3, GAP=0.
  - Response: 12 consecutive x_valid cycles with x=1,0,1,0,1,0,1,0,1,0,1,0.
  - done=1 on cycle 13 after start, err=0; busy high for cycles 1..12.
- Full-width pattern: pattern=8'hA5, len=8, reps=1.
  - Response: x=1,0,1,0,0,1,0,1 over 8 cycles; done on cycle 9.
- Gap insertion: GAP=2, pattern=3'b110, len=3, reps=2.
  - Response: 1,1,0, then 2 cycles with x_valid=0, then 1,1,0; busy for 8 cycles; done on cycle 9.
- Illegal request: len=0, reps=5, start pulse.
  - Response: busy never asserts; done=1 and err=1 on the next cycle; no x_valid.
  - Repeat with len=9 and with reps=0: same response.
- Abort and ignored start: pattern=8'hFF, len=8, reps=4; abort after the 5th bit; a second start is pulsed while busy.
  - Response: the 2nd start has no effect; x_valid drops the cycle after abort; done=1, err=0.
  - The next start with 4'b1010, len=4, reps=1 sends 1,0,1,0 cleanly.
- Async reset mid-stream: drive rst low between clock edges during SEND.
  - Response: x, x_valid and busy go to 0 immediately, without waiting for a clock edge; no done pulse.
  - After release, IDLE accepts a new start.

Source files
------------

// File: rtl/mealy_pattern_tx.sv
// Serial pattern transmitter: shifts a len-bit pattern out MSB-first, reps times,
// with GAP idle cycles between repetitions. Feeds the mealy_6 detector's x input.
module mealy_pattern_tx #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] reps,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   shadow_q, shadow_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               x_d, x_valid_d, busy_d, done_d, err_d;
  logic               req_ok;

  assign req_ok = (len != '0) && (len <= LEN_W'(PAT_W)) && (reps != '0);

  // State, shadow and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      last_q   <= '0;
      bit_q    <= '0;
      rep_q    <= '0;
      gap_q    <= '0;
      x        <= 1'b0;
      x_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      last_q   <= last_d;
      bit_q    <= bit_d;
      rep_q    <= rep_d;
      gap_q    <= gap_d;
      x        <= x_d;
      x_valid  <= x_valid_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

  // Next-state and counter update; bit_q indexes the bit presented on x this cycle
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    last_d   = last_q;
    bit_d    = bit_q;
    rep_d    = rep_q;
    gap_d    = gap_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (req_ok) begin
            shadow_d = pattern;
            last_d   = IDX_W'(len - LEN_W'(1));
            bit_d    = IDX_W'(len - LEN_W'(1));
            rep_d    = reps;
            state_d  = S_SEND;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (bit_q != '0) begin
          bit_d = bit_q - IDX_W'(1);
        end else begin
          rep_d = rep_q - CNT_W'(1);
          if (rep_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end else if (GAP != 0) begin
            gap_d   = GAP_W'(GAP - 1);
            state_d = S_GAP;
          end else begin
            bit_d = last_q;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (gap_q == '0) begin
          bit_d   = last_q;
          state_d = S_SEND;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the upcoming state
  always_comb begin
    x_valid_d = (state_d == S_SEND);
    x_d       = (state_d == S_SEND) && shadow_d[bit_d];
    busy_d    = (state_d == S_SEND) || (state_d == S_GAP);
    done_d    = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_mealy_pattern_tx.sv
// Scoreboard bench for mealy_pattern_tx: one instance with GAP=0, one with GAP=2.
module tb_mealy_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] reps = '0;
  logic       start0, start1;
  logic       x0, xv0, busy0, done0, err0;
  logic       x1, xv1, busy1, done1, err1;

  int vectors = 0;
  int miscompares = 0;
  string      q_tag[$];
  logic [4:0] q_exp[$];

  assign start0 = start & ~sel;
  assign start1 = start & sel;

  always #5 clk = ~clk;

  mealy_pattern_tx #(.PAT_W(8), .LEN_W(4), .CNT_W(4), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .pattern(pattern), .len(len), .reps(reps),
    .abort(abort), .x(x0), .x_valid(xv0), .busy(busy0), .done(done0), .err(err0));

  mealy_pattern_tx #(.PAT_W(8), .LEN_W(4), .CNT_W(4), .GAP(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pattern(pattern), .len(len), .reps(reps),
    .abort(abort), .x(x1), .x_valid(xv1), .busy(busy1), .done(done1), .err(err1));

  // Vectors are {busy, x_valid, x, done, err}
  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got {busy,xv,x,done,err}=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] obs();
    return sel ? {busy1, xv1, x1, done1, err1} : {busy0, xv0, x0, done0, err0};
  endfunction

  task automatic push(input string tag, input logic [4:0] v);
    q_tag.push_back(tag);
    q_exp.push_back(v);
  endtask

  // Reference behaviour of one request, cycle by cycle starting the cycle after start
  task automatic model(input string tag, input logic [7:0] pat, input logic [3:0] ln,
                       input logic [3:0] rp, input int gp);
    if (ln == 4'd0 || ln > 4'd8 || rp == 4'd0) begin
      push(tag, 5'b00011);
    end else begin
      for (int r = 0; r < int'(rp); r++) begin
        for (int i = int'(ln) - 1; i >= 0; i--) push(tag, {2'b11, pat[i], 2'b00});
        if (r < int'(rp) - 1) for (int g = 0; g < gp; g++) push(tag, 5'b10000);
      end
      push(tag, 5'b00010);
    end
    push(tag, 5'b00000);
  endtask

  task automatic step();
    string      t;
    logic [4:0] e;
    @(negedge clk);
    if (q_exp.size() > 0) begin
      t = q_tag.pop_front();
      e = q_exp.pop_front();
      check(t, obs(), e);
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 300 && q_exp.size() > 0; c++) step();
    check("drain_timeout", 5'(q_exp.size()), 5'd0);
    q_tag.delete();
    q_exp.delete();
  endtask

  task automatic request(input string tag, input logic s, input logic [7:0] pat,
                         input logic [3:0] ln, input logic [3:0] rp, input int gp);
    sel = s; pattern = pat; len = ln; reps = rp; start = 1'b1;
    model(tag, pat, ln, rp, gp);
    step();
    start = 1'b0;
    drain();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    sel = 1'b0; check("reset0", obs(), 5'b00000);
    sel = 1'b1; check("reset1", obs(), 5'b00000);
    sel = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    request("alt",      1'b0, 8'h0A, 4'd4, 4'd3, 0);
    request("full",     1'b0, 8'hA5, 4'd8, 4'd1, 0);
    request("gap",      1'b1, 8'h06, 4'd3, 4'd2, 2);
    request("gap_alt",  1'b1, 8'h0A, 4'd4, 4'd3, 2);
    request("ill_len0", 1'b0, 8'h0A, 4'd0, 4'd5, 0);
    request("ill_len9", 1'b0, 8'h0A, 4'd9, 4'd1, 0);
    request("ill_rep0", 1'b0, 8'h0A, 4'd4, 4'd0, 0);
    request("ill_gap",  1'b1, 8'h0A, 4'd0, 4'd2, 2);

    // Abort after the 5th bit, with an ignored start while busy and during DONE
    sel = 1'b0; pattern = 8'hFF; len = 4'd8; reps = 4'd4; start = 1'b1;
    repeat (5) push("abort_bits", 5'b11100);
    push("abort_done", 5'b00010);
    push("done_start_ign", 5'b00000);
    push("done_start_ign", 5'b00000);
    step();
    start = 1'b0;
    step();
    start = 1'b1; pattern = 8'h00; len = 4'd3; reps = 4'd1;
    step();
    start = 1'b0;
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b1; pattern = 8'h0A; len = 4'd4; reps = 4'd1;
    step();
    start = 1'b0;
    drain();
    request("abort_next", 1'b0, 8'h0A, 4'd4, 4'd1, 0);

    // Abort during a gap on the GAP=2 instance
    sel = 1'b1; pattern = 8'h07; len = 4'd3; reps = 4'd3; start = 1'b1;
    repeat (3) push("gap_abort_bits", 5'b11100);
    push("gap_abort_gap", 5'b10000);
    push("gap_abort_done", 5'b00010);
    push("gap_abort_idle", 5'b00000);
    step();
    start = 1'b0;
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    drain();

    // Asynchronous reset mid-stream
    sel = 1'b0; pattern = 8'hC3; len = 4'd8; reps = 4'd2; start = 1'b1;
    push("rst_pre", 5'b11100);
    push("rst_pre", 5'b11100);
    push("rst_pre", 5'b11000);
    step();
    start = 1'b0;
    step();
    step();
    #2 rst = 1'b0;
    #1 check("async_rst", obs(), 5'b00000);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold", obs(), 5'b00000);
    end
    rst = 1'b1;
    push("rst_no_done", 5'b00000);
    push("rst_no_done", 5'b00000);
    drain();
    request("after_rst", 1'b0, 8'hA5, 4'd8, 4'd2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
